dp_issue: RTL and testbench
===========================

DP_ISSUE -- requirements
Module: dp_issue

Interface
REQ-001 Parameter N, default 32, datapath width of operands and immediate.
REQ-002 Parameter CW, default 16, width of the issued and skipped counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction word presented.
REQ-006 instr  input  32  ARM data-processing instruction word.
REQ-007 instr_ready  output  1  block accepts instr this cycle.
REQ-008 alu_valid  output  1  one-cycle issue strobe to ALU.
REQ-009 opcode  output  4  instr[24:21], held from accept until next accept.
REQ-010 rn, rd, rm  output  4 each  instr[19:16], instr[15:12], instr[3:0].
REQ-011 use_imm  output  1  instr[25]; operand_2 is imm_operand when 1, register rm when 0.
REQ-012 imm_operand  output  N  instr[7:0] rotated right by 2*instr[11:8].
REQ-013 c_to_alu  output  1  shifter carry out for the ALU's logical ops.
REQ-014 nzcv  output  4  architectural flag register {N,Z,C,V}, feeds ALU old flags.
REQ-015 alu_done  input  1  ALU result and flags valid.
REQ-016 alu_nzcv  input  4  flags computed by ALU.
REQ-017 rd_we  output  1  register-file write strobe for rd.
REQ-018 skip_pulse, illegal_pulse  output  1 each  condition-failed / rejected instruction.
REQ-019 issued_count, skipped_count  output  CW each  statistics counters.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, SKIP, ILLEGAL; instr_ready = 1 only in IDLE.
REQ-021 Accept occurs when instr_valid and instr_ready are both high; decoded fields register on that edge.
REQ-022 Illegal on accept: instr[27:26] != 00; or opcode 8-11 with instr[20]=0; or use_imm=0 with instr[11:4] != 0 -> ILLEGAL.
REQ-023 Condition instr[31:28] evaluates against nzcv at accept cycle per ARM EQ..AL; 1111 (NV) never passes.
REQ-024 Legal and passing -> ISSUE; legal and failing -> SKIP; illegal takes priority over condition.
REQ-025 ISSUE: alu_valid = 1 for exactly one cycle, then WAIT; issued_count increments on that edge.
REQ-026 WAIT: hold all decoded outputs until alu_done = 1; alu_done outside WAIT is ignored.
REQ-027 On alu_done in WAIT: rd_we = 1 in same cycle (combinational) unless opcode is 8-11; next state IDLE.
REQ-028 On alu_done in WAIT with instr[20]=1: nzcv <= alu_nzcv on that edge; otherwise nzcv unchanged.
REQ-029 SKIP: skip_pulse = 1 one cycle, skipped_count increments, next IDLE; no alu_valid, no rd_we.
REQ-030 ILLEGAL: illegal_pulse = 1 one cycle, next IDLE; no counter changes.
REQ-031 c_to_alu = nzcv[1] when rotate field is 0 or use_imm = 0, else imm_operand[N-1].
REQ-032 Counters wrap from all-ones to 0 without saturation.
REQ-033 Minimum latency: accept at edge t, alu_valid high in cycle t+1, alu_done earliest in cycle t+2; next accept earliest edge t+3.

Reset
REQ-034 reset high immediately forces IDLE, nzcv = 0000, both counters = 0, all decoded fields = 0.
REQ-035 While reset high: instr_ready = 0, alu_valid = rd_we = skip_pulse = illegal_pulse = 0.
REQ-036 Reset mid-operation discards the in-flight instruction; no rd_we or flag update follows it.

Verification
REQ-037 instr 0xE3A010FF (MOVAL r1,#255), alu_done one cycle after alu_valid -> opcode 13, rd 1, imm_operand 0x000000FF, rd_we pulse, nzcv unchanged, issued_count 1.
REQ-038 instr 0xE3B004FF (MOVS r0,#0xFF000000) with alu_nzcv 1000 -> imm_operand 0xFF000000, c_to_alu 1, nzcv 1000 after alu_done.
REQ-039 nzcv 0000, instr 0x03A01001 (MOVEQ) -> skip_pulse, skipped_count 1, no alu_valid; then nzcv 0100 same instr -> issued.
REQ-040 instr 0xE1500001 (CMP r0,r1) with alu_nzcv 0110 -> no rd_we, nzcv 0110; instr 0xE1000001 (opcode 8, S=0) -> illegal_pulse only.
REQ-041 instr 0xEA000000 (branch) -> illegal_pulse, no alu_valid; reset asserted in WAIT -> IDLE, nzcv 0000, no rd_we when alu_done later arrives.
REQ-042 Force issued_count to all-ones via 2^CW issues (CW=4 build) -> 16th issue wraps count to 0.

Source files
------------

// File: rtl/dp_issue.sv
// dp_issue: decode/issue stage for ARM data-processing instructions.
// Accepts one instruction at a time, decodes its fields and the rotated
// immediate, and checks the condition code against the flag register.
// A passing instruction gets a one-cycle strobe to the ALU, then the
// stage waits for alu_done. A failing instruction is skipped, and an
// instruction outside the supported class is rejected.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   instr_valid/instr   instruction word in; instr_ready high only in IDLE
//   alu_valid           one-cycle issue strobe
//   opcode,rn,rd,rm     decoded fields, held from accept to next accept
//   use_imm             operand 2 is imm_operand (1) or register rm (0)
//   imm_operand         instr[7:0] rotated right by 2*instr[11:8]
//   c_to_alu            shifter carry out for logical ops
//   nzcv                architectural flags {N,Z,C,V}
//   alu_done/alu_nzcv   ALU completion and its computed flags
//   rd_we               register-file write strobe (combinational)
//   skip_pulse          condition failed
//   illegal_pulse       instruction rejected
//   issued_count        instructions sent to the ALU (wrapping)
//   skipped_count       instructions skipped (wrapping)

module dp_issue #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [31:0]   instr,
    output logic          instr_ready,
    output logic          alu_valid,
    output logic [3:0]    opcode,
    output logic [3:0]    rn,
    output logic [3:0]    rd,
    output logic [3:0]    rm,
    output logic          use_imm,
    output logic [N-1:0]  imm_operand,
    output logic          c_to_alu,
    output logic [3:0]    nzcv,
    input  logic          alu_done,
    input  logic [3:0]    alu_nzcv,
    output logic          rd_we,
    output logic          skip_pulse,
    output logic          illegal_pulse,
    output logic [CW-1:0] issued_count,
    output logic [CW-1:0] skipped_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        SKIP    = 3'd3,
        ILLEGAL = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    opcode_q;
    logic [3:0]    rn_q;
    logic [3:0]    rd_q;
    logic [3:0]    rm_q;
    logic          use_imm_q;
    logic [N-1:0]  imm_q;
    logic [3:0]    rot_q;
    logic          s_q;
    logic [3:0]    nzcv_q, nzcv_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] skipped_q, skipped_d;

    logic          accept;
    logic          load;
    logic          dec_illegal;
    logic          dec_pass;
    logic [N-1:0]  dec_imm;
    logic          test_op_q;

    // ARM condition field evaluated against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cc,
                                       input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c && !z;
            4'h9:    r = !c || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Zero-extend the 8-bit immediate and rotate it right within N bits;
    // duplicating the word turns the rotate into a plain shift.
    function automatic logic [N-1:0] ror_imm(input logic [7:0] v,
                                             input logic [3:0] rot);
        logic [N-1:0]   ext;
        logic [2*N-1:0] dbl;
        int             sh;
        ext = N'(v);
        sh  = (int'(rot) * 2) % N;
        dbl = {ext, ext} >> sh;
        return dbl[N-1:0];
    endfunction

    assign instr_ready = (state_q == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;

    // Only the immediate / unshifted-register data-processing class is
    // handled; compare-type opcodes without S have no architectural effect.
    always_comb begin
        dec_illegal = 1'b0;
        if (instr[27:26] != 2'b00) begin
            dec_illegal = 1'b1;
        end
        if (instr[24:23] == 2'b10 && !instr[20]) begin
            dec_illegal = 1'b1;
        end
        if (!instr[25] && instr[11:4] != 8'h00) begin
            dec_illegal = 1'b1;
        end
    end

    assign dec_pass = cond_pass(instr[31:28], nzcv_q);
    assign dec_imm  = ror_imm(instr[7:0], instr[11:8]);

    // Opcodes 8-11 (TST/TEQ/CMP/CMN) only set flags
    assign test_op_q = (opcode_q[3:2] == 2'b10);

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        alu_valid     = 1'b0;
        rd_we         = 1'b0;
        skip_pulse    = 1'b0;
        illegal_pulse = 1'b0;
        nzcv_d        = nzcv_q;
        issued_d      = issued_q;
        skipped_d     = skipped_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (dec_illegal) begin
                        state_d = ILLEGAL;
                    end else if (dec_pass) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = SKIP;
                    end
                end
            end
            ISSUE: begin
                alu_valid = 1'b1;
                issued_d  = issued_q + CW'(1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    rd_we = !test_op_q;
                    if (s_q) begin
                        nzcv_d = alu_nzcv;
                    end
                    state_d = IDLE;
                end
            end
            SKIP: begin
                skip_pulse = 1'b1;
                skipped_d  = skipped_q + CW'(1);
                state_d    = IDLE;
            end
            ILLEGAL: begin
                illegal_pulse = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv_q    <= 4'h0;
            issued_q  <= '0;
            skipped_q <= '0;
        end else begin
            nzcv_q    <= nzcv_d;
            issued_q  <= issued_d;
            skipped_q <= skipped_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q  <= 4'h0;
            rn_q      <= 4'h0;
            rd_q      <= 4'h0;
            rm_q      <= 4'h0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            rot_q     <= 4'h0;
            s_q       <= 1'b0;
        end else if (load) begin
            opcode_q  <= instr[24:21];
            rn_q      <= instr[19:16];
            rd_q      <= instr[15:12];
            rm_q      <= instr[3:0];
            use_imm_q <= instr[25];
            imm_q     <= dec_imm;
            rot_q     <= instr[11:8];
            s_q       <= instr[20];
        end
    end

    assign opcode        = opcode_q;
    assign rn            = rn_q;
    assign rd            = rd_q;
    assign rm            = rm_q;
    assign use_imm       = use_imm_q;
    assign imm_operand   = imm_q;
    assign nzcv          = nzcv_q;
    assign issued_count  = issued_q;
    assign skipped_count = skipped_q;

    // A zero rotate (or a register operand) passes the old carry through
    assign c_to_alu = (use_imm_q && rot_q != 4'h0) ? imm_q[N-1] : nzcv_q[1];

endmodule

// File: tb/tb_dp_issue.sv
// tb_dp_issue: directed and randomized checks of dp_issue against a
// behavioural model of decode, condition, flag and counter rules.

module tb_dp_issue;

    localparam int N  = 32;
    localparam int CW = 4;
    localparam int CMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic          alu_valid;
    logic [3:0]    opcode, rn, rd, rm;
    logic          use_imm;
    logic [N-1:0]  imm_operand;
    logic          c_to_alu;
    logic [3:0]    nzcv;
    logic          alu_done;
    logic [3:0]    alu_nzcv;
    logic          rd_we;
    logic          skip_pulse;
    logic          illegal_pulse;
    logic [CW-1:0] issued_count;
    logic [CW-1:0] skipped_count;

    always #5 clk = ~clk;

    dp_issue #(.N(N), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .alu_valid     (alu_valid),
        .opcode        (opcode),
        .rn            (rn),
        .rd            (rd),
        .rm            (rm),
        .use_imm       (use_imm),
        .imm_operand   (imm_operand),
        .c_to_alu      (c_to_alu),
        .nzcv          (nzcv),
        .alu_done      (alu_done),
        .alu_nzcv      (alu_nzcv),
        .rd_we         (rd_we),
        .skip_pulse    (skip_pulse),
        .illegal_pulse (illegal_pulse),
        .issued_count  (issued_count),
        .skipped_count (skipped_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_nzcv;
    int         m_issued;
    int         m_skipped;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_cond(input logic [3:0] cc,
                                  input logic [3:0] f);
        bit n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        logic [31:0] v;
        int          r;
        v = {24'h0, ins[7:0]};
        r = 2 * int'(ins[11:8]);
        if (r == 0) return v;
        return (v >> r) | (v << (32 - r));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(1) == 0) w[31:28] = 4'hE;
        if ($urandom_range(7) != 0) w[27:26] = 2'b00;
        if (!w[25] && $urandom_range(3) != 0) w[11:4] = 8'h00;
        if (w[24:23] == 2'b10 && $urandom_range(3) != 0) w[20] = 1'b1;
        return w;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [3:0] anz,
                        input int dly);
        bit          ill, pass, tst;
        logic [31:0] ei;
        ill  = (ins[27:26] != 2'b00)
            || (ins[24:21] inside {[4'd8:4'd11]} && !ins[20])
            || (!ins[25] && ins[11:4] != 8'h00);
        pass = m_cond(ins[31:28], m_nzcv);
        tst  = ins[24:21] inside {[4'd8:4'd11]};
        ei   = m_imm(ins);

        chk("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;

        chk("opcode", opcode, ins[24:21]);
        chk("rn", rn, ins[19:16]);
        chk("rd", rd, ins[15:12]);
        chk("rm", rm, ins[3:0]);
        chk("use_imm", use_imm, ins[25]);
        chk("imm", imm_operand, ei);
        chk("ready_busy", instr_ready, 0);
        chk("alu_valid", alu_valid, !ill && pass);
        chk("skip_pulse", skip_pulse, !ill && !pass);
        chk("illegal_pulse", illegal_pulse, ill);

        if (!ill && pass) begin
            m_issued++;
            @(posedge clk);
            #1;
            chk("alu_valid_once", alu_valid, 0);
            chk("issued_cnt", issued_count, m_issued % CMOD);
            chk("c_to_alu", c_to_alu,
                (ins[25] && ins[11:8] != 4'h0) ? ei[31] : m_nzcv[1]);
            for (int k = 0; k < dly; k++) begin
                chk("early_we", rd_we, 0);
                @(posedge clk);
                #1;
            end
            alu_done = 1'b1;
            alu_nzcv = anz;
            #1;
            chk("rd_we", rd_we, !tst);
            @(posedge clk);
            #1;
            alu_done = 1'b0;
            if (ins[20]) m_nzcv = anz;
        end else begin
            // alu_done outside WAIT must have no effect
            alu_done = 1'b1;
            alu_nzcv = anz;
            #1;
            chk("stray_we", rd_we, 0);
            @(posedge clk);
            #1;
            alu_done = 1'b0;
            if (!ill) m_skipped++;
        end
        chk("nzcv", nzcv, m_nzcv);
        chk("issued_end", issued_count, m_issued % CMOD);
        chk("skipped_end", skipped_count, m_skipped % CMOD);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'hE3A010FF;
        alu_done    = 1'b1;
        alu_nzcv    = 4'hF;
        m_nzcv      = 4'h0;
        m_issued    = 0;
        m_skipped   = 0;

        #2;
        chk("rst_ready", instr_ready, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_rd_we", rd_we, 0);
        chk("rst_nzcv", nzcv, 0);
        chk("rst_issued", issued_count, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_imm", imm_operand, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_opcode", opcode, 0);
        chk("rst_skip", skip_pulse, 0);
        instr_valid = 1'b0;
        alu_done    = 1'b0;
        alu_nzcv    = 4'h0;
        reset       = 1'b0;
        #1;

        step(32'hE3A010FF, 4'h0, 0);
        step(32'hE3B004FF, 4'h8, 0);
        chk("movs_nzcv", nzcv, 4'h8);
        step(32'h03A01001, 4'h0, 0);
        chk("moveq_skip_cnt", skipped_count, 1);
        step(32'hE1500001, 4'h6, 1);
        chk("cmp_nzcv", nzcv, 4'h6);
        step(32'h03A01001, 4'h0, 2);
        step(32'hE1000001, 4'h3, 0);
        step(32'hEA000000, 4'h3, 0);

        // reset while waiting on the ALU
        instr_valid = 1'b1;
        instr       = 32'hE3B004FF;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("wrst_ready", instr_ready, 0);
        chk("wrst_nzcv", nzcv, 0);
        chk("wrst_issued", issued_count, 0);
        chk("wrst_opcode", opcode, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_nzcv    = 4'h0;
        m_issued  = 0;
        m_skipped = 0;
        #1;
        chk("wrst_idle", instr_ready, 1);
        alu_done = 1'b1;
        alu_nzcv = 4'hF;
        #1;
        chk("wrst_no_we", rd_we, 0);
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        chk("wrst_nzcv_kept", nzcv, 0);

        // sixteen issues wrap the 4-bit counter
        for (int i = 0; i < CMOD; i++) begin
            step(32'hE3A01000 | 32'(i), 4'h0, $urandom_range(2));
        end
        chk("wrap", issued_count, 0);

        for (int i = 0; i < 250; i++) begin
            step(rnd_instr(), 4'($urandom), $urandom_range(3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
